rstack_ctrl: RTL
================

# rstack_ctrl

Return-stack controller for the CPU: owns the stack pointer and presents a push/pop port to the sequencer (call/ret), keeping the top entry in a register and spilling older entries into the 1R1W return-stack memory. It drives that memory's write port synchronously and its asynchronous read port combinationally. It tracks depth, flags full/empty, and latches overflow/underflow into a sticky fault state that blocks further stack traffic until cleared.

## Interface
- WIDTH, 4: memory address width; SIZE must equal 2**WIDTH
- SIZE, 16: memory entries; total capacity = SIZE+1 (memory + top register)
- DATA_WIDTH, 13: return-address width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- push  in  1  push push_data this cycle
- pop  in  1  pop top this cycle
- push_data  in  DATA_WIDTH  value to push
- clear  in  1  leave FAULT, clear error flags (stack contents kept)
- top  out  DATA_WIDTH  current top of stack (registered)
- depth  out  WIDTH+1  number of valid entries, 0..SIZE+1
- empty  out  1  depth==0
- full  out  1  depth==SIZE+1
- overflow  out  1  sticky, push attempted while full
- underflow  out  1  sticky, pop attempted while empty
- we  out  1  memory write enable
- mem_din_addr  out  WIDTH  memory write address
- mem_din  out  DATA_WIDTH  memory write data
- mem_dout_addr  out  WIDTH  memory read address
- mem_dout  in  DATA_WIDTH  memory async read data

## Operation
- Internal mem_cnt (WIDTH+1 bits) = entries held in memory = max(depth-1, 0); depth = mem_cnt + (tos_valid).
- States: EMPTY (depth 0), ACTIVE (depth ≥1), FAULT.
- EMPTY: push only -> top<=push_data, depth 1, ACTIVE, no memory write. Pop (with or without push) -> underflow<=1, FAULT, nothing else changes.
- ACTIVE, push only, not full: we=1, mem_din_addr=mem_cnt[WIDTH-1:0], mem_din=top (old); top<=push_data; mem_cnt++.
- ACTIVE, push only, full: we=0, overflow<=1, FAULT, contents unchanged.
- ACTIVE, pop only, mem_cnt>0: top<=mem_dout, mem_cnt--. mem_cnt==0: depth->0, top holds stale value, EMPTY.
- ACTIVE, push and pop together (any depth incl. full): top<=push_data, depth unchanged, we=0 (replace; no overflow).
- mem_dout_addr = (mem_cnt-1)[WIDTH-1:0] always (wraps to SIZE-1 at mem_cnt 0; value unused then).
- FAULT: push/pop ignored, we=0. clear -> overflow/underflow<=0, next state EMPTY if depth==0 else ACTIVE. clear has priority over push/pop in the same cycle (they are ignored that cycle). clear outside FAULT: no effect.
- Flags only set on error, only cleared by clear or reset.

## Timing
- Reset (async): state EMPTY, top 0, depth 0, empty 1, full 0, overflow 0, underflow 0; we 0 while reset asserted.
- we, mem_din_addr, mem_din, mem_dout_addr combinational from current state and inputs; memory writes on the same edge that advances the pointer.
- top/depth/flags reflect an operation one edge later (zero extra latency); back-to-back push/pop every cycle supported.
- Pop reads mem_dout combinationally in the pop cycle; no read-before-write hazard since push and pop never write and read the same cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight write is suppressed (we forced 0).

## Test plan
- Reset, then push 0x100,0x101,0x102 -> top 0x102, depth 3, writes at addr 0 (0x100), addr 1 (0x101); three pops -> top 0x101, 0x100, then empty=1, depth 0.
- Push 17 values 0x000..0x010 (SIZE=16) -> full=1, depth 17, top 0x010; 18th push 0x1FF -> overflow=1, FAULT, top still 0x010, we=0.
- From full, push+pop with 0x0AA -> top 0x0AA, depth 17, overflow 0; then 17 pops return 0x0AA,0x00F..0x000 in order.
- Pop on empty -> underflow=1; following push 0x055 ignored (depth 0); clear -> flags 0, EMPTY; push 0x055 -> top 0x055, depth 1.
- Push 5 values, assert reset asynchronously mid-cycle with push high -> outputs return to reset values before next edge, no memory write.
- Overflow with clear and push in same cycle -> flags clear, push ignored, state ACTIVE, depth 17.

Source files
------------

// File: rtl/rstack_ctrl.sv
// Return-stack controller: top entry in a register, older entries spilled
// to an external 1R1W memory (sync write, async read); sticky fault state.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   push, pop          stack requests (both together replace the top)
//   push_data          value to push
//   clear              leave FAULT and clear overflow/underflow
//   top                registered top of stack
//   depth              valid entries, 0..SIZE+1
//   empty, full        depth == 0 / depth == SIZE+1
//   overflow/underflow sticky error flags
//   we, mem_din_addr,  memory write port
//   mem_din
//   mem_dout_addr,     memory async read port
//   mem_dout
module rstack_ctrl #(
    parameter int WIDTH      = 4,
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] top,
    output logic [WIDTH:0]        depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  we,
    output logic [WIDTH-1:0]      mem_din_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [WIDTH-1:0]      mem_dout_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [WIDTH:0]   CNT_ONE   = 1;
    localparam logic [WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [WIDTH:0]   DEPTH_MAX = (WIDTH + 1)'(SIZE + 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic [WIDTH:0]        cnt_q, cnt_d;
    logic                  tv_q, tv_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  we_d;

    assign depth         = cnt_q + {{WIDTH{1'b0}}, tv_q};
    assign empty         = (depth == '0);
    assign full          = (depth == DEPTH_MAX);
    assign top           = top_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;
    assign mem_din_addr  = cnt_q[WIDTH-1:0];
    assign mem_din       = top_q;
    // Wraps at cnt 0; the read value is never used in that case.
    assign mem_dout_addr = cnt_q[WIDTH-1:0] - ADDR_ONE;
    // An in-flight spill must not land while reset is held.
    assign we            = we_d & ~reset;

    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        tv_d    = tv_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we_d    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (pop) begin
                    unf_d   = 1'b1;
                    state_d = FAULT;
                end else if (push) begin
                    top_d   = push_data;
                    tv_d    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (push && pop) begin
                    top_d = push_data;
                end else if (push) begin
                    if (full) begin
                        ovf_d   = 1'b1;
                        state_d = FAULT;
                    end else begin
                        we_d  = 1'b1;
                        top_d = push_data;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (pop) begin
                    if (cnt_q != '0) begin
                        top_d = mem_dout;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        // Top keeps its stale value; only validity drops.
                        tv_d    = 1'b0;
                        state_d = EMPTY;
                    end
                end
            end
            FAULT: begin
                if (clear) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = empty ? EMPTY : ACTIVE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
            tv_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            tv_q  <= tv_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule
